// File: rtl/modulo_decod_coord_linha.sv
// Purpose: row-coordinate decoder; a debounced confirm press captures cdl, range-checks it, returns mdl.
// Latency: press event -> mdl_valid (or erro) high in 2 cycles; confirma rise -> press event 2+DEB_CYCLES+1.
// Backpressure: mdl/mdl_valid held until ack; presses arriving while busy are dropped, never queued.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   cdl[3:0]          row coordinate from switches (legal only when cdl[3]=0)
//   confirma          raw confirm button, asynchronous to clk
//   ack               consumer accepts mdl (only looked at while mdl_valid=1)
//   mdl[2:0]          decoded row index, keeps its last value after the handshake
//   mdl_valid         mdl holds an unaccepted index
//   erro              held ERR_HOLD cycles after an illegal code
//   ocupado           controller is not idle
//   linha_oh[7:0]     one-hot row enable, present only when LINHA_ONEHOT_EN is defined
//
// Optional feature macro: LINHA_ONEHOT_EN
module modulo_decod_coord_linha #(
  parameter int DEB_CYCLES = 4,
  parameter int ERR_HOLD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cdl,
  input  logic       confirma,
  input  logic       ack,
  output logic [2:0] mdl,
  output logic       mdl_valid,
  output logic       erro,
  output logic       ocupado
`ifdef LINHA_ONEHOT_EN
  ,
  output logic [7:0] linha_oh
`endif
);

  localparam logic [7:0] DEB_LIM  = 8'(DEB_CYCLES);
  localparam logic [7:0] HOLD_LIM = 8'(ERR_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning: 2-flop synchroniser, debounce, rising-edge detect
  // ---------------------------------------------------------------------------
  logic       sync_s1;
  logic       sync_s2;
  logic       deb_lvl;
  logic       deb_lvl_q;
  logic [7:0] deb_cnt;
  logic [7:0] deb_cnt_inc;
  logic       press;

  // Saturating increment so a stuck mismatch can never wrap the counter.
  assign deb_cnt_inc = (deb_cnt == 8'hFF) ? 8'hFF : deb_cnt + 8'd1;

  // One-cycle pulse on the 0->1 transition of the debounced level; holding the
  // button keeps deb_lvl high and therefore yields only this single pulse.
  assign press = deb_lvl & ~deb_lvl_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_s1   <= 1'b0;
      sync_s2   <= 1'b0;
      deb_lvl   <= 1'b0;
      deb_lvl_q <= 1'b0;
      deb_cnt   <= 8'd0;
    end else begin
      sync_s1   <= confirma;
      sync_s2   <= sync_s1;
      deb_lvl_q <= deb_lvl;
      if (sync_s2 != deb_lvl) begin
        // Level flips only after DEB_CYCLES consecutive disagreeing samples.
        if (deb_cnt_inc == DEB_LIM) begin
          deb_lvl <= sync_s2;
          deb_cnt <= 8'd0;
        end else begin
          deb_cnt <= deb_cnt_inc;
        end
      end else begin
        deb_cnt <= 8'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t     state;
  logic [3:0] cap;
  logic [7:0] err_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cap       <= 4'd0;
      err_cnt   <= 8'd0;
      mdl       <= 3'b000;
      mdl_valid <= 1'b0;
      erro      <= 1'b0;
      ocupado   <= 1'b0;
`ifdef LINHA_ONEHOT_EN
      linha_oh  <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            cap     <= cdl;
            state   <= CHECK;
            ocupado <= 1'b1;
          end
        end

        CHECK: begin
          if (!cap[3]) begin
            mdl       <= cap[2:0];
            mdl_valid <= 1'b1;
`ifdef LINHA_ONEHOT_EN
            linha_oh  <= 8'h01 << cap[2:0];
`endif
            state     <= VALID;
          end else begin
            // mdl is deliberately left untouched on an illegal code.
            err_cnt <= HOLD_LIM;
            erro    <= 1'b1;
            state   <= ERROR;
          end
        end

        VALID: begin
          // A press arriving here is dropped; ack always wins.
          if (ack) begin
            mdl_valid <= 1'b0;
`ifdef LINHA_ONEHOT_EN
            linha_oh  <= 8'h00;
`endif
            ocupado   <= 1'b0;
            state     <= IDLE;
          end
        end

        ERROR: begin
          // erro is high for counts ERR_HOLD..1, i.e. exactly ERR_HOLD cycles;
          // the counter never goes below 1.
          if (err_cnt <= 8'd1) begin
            erro    <= 1'b0;
            ocupado <= 1'b0;
            state   <= IDLE;
          end else begin
            err_cnt <= err_cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_decod_coord_linha.sv
module tb_modulo_decod_coord_linha;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cdl = 4'd0;
  logic       confirma = 1'b0;
  logic       ack = 1'b0;
  logic [2:0] mdl;
  logic       mdl_valid;
  logic       erro;
  logic       ocupado;
`ifdef LINHA_ONEHOT_EN
  logic [7:0] linha_oh;
`endif

  always #5 clk = ~clk;

  modulo_decod_coord_linha #(.DEB_CYCLES(DEB), .ERR_HOLD(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .cdl(cdl),
    .confirma(confirma),
    .ack(ack),
    .mdl(mdl),
    .mdl_valid(mdl_valid),
    .erro(erro),
    .ocupado(ocupado)
`ifdef LINHA_ONEHOT_EN
    ,
    .linha_oh(linha_oh)
`endif
  );

  // Expected output word: {linha_oh, mdl, mdl_valid, erro, ocupado}
  typedef logic [13:0] exp_t;
  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // ---------------------------------------------------------------------------
  // Reference model: behaviour described as "how long since", not as states.
  // ---------------------------------------------------------------------------
  bit   m_hist[$];        // raw button samples, newest at the back
  bit   m_lvl, m_lvl_d;   // debounced level and its value one cycle ago
  int   m_run;            // consecutive samples disagreeing with m_lvl
  bit   m_chk;            // a code was captured last cycle and is being checked
  logic [3:0] m_cap;
  logic [2:0] m_mdl;
  bit   m_valid;
  int   m_err;            // remaining cycles of erro

  function automatic void model_reset();
    m_hist = '{1'b0, 1'b0};
    m_lvl = 0; m_lvl_d = 0; m_run = 0;
    m_chk = 0; m_cap = 0; m_mdl = 0; m_valid = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit r, input bit c, input logic [3:0] d, input bit a);
    bit press;
    bit s2;
    if (r) begin
      model_reset();
      return;
    end
    press = m_lvl && !m_lvl_d;
    s2 = m_hist[0];          // sample taken two cycles ago
    m_lvl_d = m_lvl;
    if (s2 != m_lvl) begin
      m_run++;
      if (m_run >= DEB) begin
        m_lvl = s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(c);

    if (m_chk) begin
      m_chk = 0;
      if (m_cap < 8) begin
        m_mdl = m_cap[2:0];
        m_valid = 1;
      end else begin
        m_err = HOLD;
      end
    end else if (m_valid) begin
      if (a) m_valid = 0;
    end else if (m_err > 0) begin
      m_err--;
    end else if (press) begin
      m_cap = d;
      m_chk = 1;
    end
  endfunction

  function automatic exp_t model_out();
    logic [7:0] oh;
    bit busy;
    oh = m_valid ? (8'h01 << m_mdl) : 8'h00;
    busy = m_chk || m_valid || (m_err > 0);
    return {oh, m_mdl, m_valid, (m_err > 0), busy};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic tick(input bit r, input bit c, input logic [3:0] d, input bit a);
    @(negedge clk);
    reset = r; confirma = c; cdl = d; ack = a;
    @(posedge clk);
    model_step(r, c, d, a);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) tick(0, 0, d, 0);
  endtask

  task automatic hold(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) tick(0, 1, d, 0);
  endtask

  // Wait (bounded) until the model shows a pending valid index, keep the button at c.
  task automatic wait_valid(input bit c, input logic [3:0] d);
    int n = 0;
    while (!m_valid && n < 100) begin
      tick(0, c, d, 0);
      n++;
    end
    if (!m_valid) begin
      $display("FAIL wait_valid: model never reached valid within %0d cycles (got 0, need 1)", n);
      miscompares++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one comparison per cycle, away from the active edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
`ifdef LINHA_ONEHOT_EN
      g = {linha_oh, mdl, mdl_valid, erro, ocupado};
`else
      g = {8'h00, mdl, mdl_valid, erro, ocupado};
      e[13:6] = 8'h00;
`endif
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got oh=%h mdl=%0d v=%b e=%b o=%b, expected oh=%h mdl=%0d v=%b e=%b o=%b",
                 cycle, g[13:6], g[5:3], g[2], g[1], g[0], e[13:6], e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit c;
    int left;
    logic [3:0] d;
    model_reset();

    // Reset, then 20 quiet cycles.
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    idle(20, 4'd0);

    // Legal code 0101, clean press held 10, ack three cycles after valid rises.
    hold(10, 4'b0101);
    wait_valid(0, 4'b0101);
    idle(2, 4'b0101);
    tick(0, 0, 4'b0101, 1);
    idle(5, 4'b0101);

    // Illegal code 1010: erro window, mdl unchanged.
    hold(10, 4'b1010);
    idle(HOLD + 10, 4'b1010);

    // Bouncy button: toggles every 2 cycles for 12 cycles, then stays high.
    for (int i = 0; i < 12; i++) tick(0, (i / 2) % 2 == 0, 4'b0010, 0);
    hold(12, 4'b0010);
    wait_valid(1, 4'b0010);
    tick(0, 1, 4'b0010, 1);
    idle(12, 4'b0010);

    // Second press while VALID is ignored.
    hold(10, 4'b0011);
    wait_valid(0, 4'b0011);
    idle(8, 4'b0011);
    hold(12, 4'b0110);
    idle(10, 4'b0110);
    tick(0, 0, 4'b0110, 1);
    idle(15, 4'b0110);

    // Press and ack in the same VALID cycle: press dropped.
    hold(10, 4'b0001);
    wait_valid(0, 4'b0001);
    hold(DEB + 2, 4'b0100);
    for (int i = 0; i < 20 && !(m_lvl && !m_lvl_d); i++) tick(0, 1, 4'b0100, 0);
    tick(0, 1, 4'b0100, 1);
    idle(15, 4'b0100);

    // Reset during ERROR at count 5.
    hold(10, 4'b1111);
    for (int i = 0; i < 40 && m_err != 5; i++) tick(0, 0, 4'b1111, 0);
    tick(1, 0, 4'b1111, 0);
    idle(10, 4'b0111);
    hold(10, 4'b0111);
    wait_valid(0, 4'b0111);
    tick(1, 0, 4'b0111, 0);   // reset during VALID
    idle(10, 4'b0110);
    hold(10, 4'b0110);
    wait_valid(0, 4'b0110);
    tick(0, 0, 4'b0110, 1);
    idle(10, 4'b0110);

    // Randomised phase.
    c = 0; left = 0; d = 4'd0;
    for (int i = 0; i < 2500; i++) begin
      if (left == 0) begin
        c = !c;
        left = $urandom_range(1, 14);
        if (!c) d = 4'($urandom_range(0, 15));
      end
      left--;
      tick($urandom_range(0, 299) == 0, c, d, $urandom_range(0, 3) == 0);
    end
    idle(HOLD + 20, d);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modulo_decod_coord_linha.md
Name: modulo_decod_coord_linha

Overview:
Receive-side partner of the row-coordinate encoder: reads a 4-bit row coordinate (cdl) from player switches and returns the 3-bit matrix row index (mdl).
- Capture is triggered by a debounced confirm button.
- The code is range-checked: only cdl[3]=0 is legal.
- A valid index is presented with a valid/ack handshake to the game controller.
- An illegal code raises a timed error flag for the LED/display logic.

Parameters:
DEB_CYCLES, 4, consecutive identical synchronised samples required before the debounced button level changes (1..255).
ERR_HOLD, 8, cycles erro stays high after an illegal code (1..255).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cdl  input  4  row coordinate from switches; static while the button is pressed
confirma  input  1  raw confirm button, active high, asynchronous to clk
ack  input  1  consumer accepts mdl; sampled only while mdl_valid=1
mdl  output  3  decoded row index 0..7
mdl_valid  output  1  mdl holds an unaccepted valid index
erro  output  1  last captured code was illegal
ocupado  output  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; state=IDLE; synchroniser, debounce counter and debounced level cleared; mdl=3'b000.
- Synchroniser: confirma passes through 2 flops (s2). Debounce: if s2 differs from the debounced level, increment the counter; when the count reaches DEB_CYCLES, the level takes s2 and the counter clears. If s2 equals the level, the counter clears.
- Press event: one-cycle pulse on the 0->1 transition of the debounced level. Press latency from confirma rising to the event is 2+DEB_CYCLES cycles (+1 for the edge register).
- FSM:
  - IDLE: on a press event, register cdl into cap and go to CHECK.
  - CHECK (1 cycle):
    - If cap[3]=0: mdl<=cap[2:0], go to VALID.
    - Else: load the error counter with ERR_HOLD and go to ERROR.
  - VALID: mdl_valid=1 and mdl stable. On ack=1, clear mdl_valid next cycle and go to IDLE. mdl keeps its last value after the handshake.
  - ERROR: erro=1 and the counter decrements. At 1, go to IDLE next cycle; erro falls on that transition. mdl is unchanged.
- Latency: press event -> mdl_valid high = 2 cycles. Press event -> erro high = 2 cycles.
- Press events in CHECK, VALID and ERROR are discarded, not queued. A press event and ack in the same VALID cycle: ack completes; the press is dropped.
- ack while not in VALID is ignored.
- The button must be released (debounced level back to 0) and pressed again to produce a new event. Holding the button produces a single event.
- Reset asserted mid-operation (any state) returns to the reset values on the next clk edge; no pending event survives.
- Counters saturate and never wrap: the debounce counter is 8 bits; the error counter stops at 1.

Optional Feature:
Macro LINHA_ONEHOT_EN.
- Defined: adds output linha_oh [7:0]. In VALID, linha_oh = 1<<mdl; otherwise it is 8'h00. Reset value is 8'h00. It is registered alongside mdl_valid and directly drives row-enable lines of the LED matrix.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle 20 cycles, no press -> mdl=0, mdl_valid=0, erro=0, ocupado=0 throughout.
- cdl=4'b0101, clean press held 10 cycles, ack 3 cycles after mdl_valid rises -> mdl_valid high exactly 2 cycles after the press event, mdl=3'b101, then low one cycle after ack, state IDLE; LINHA_ONEHOT_EN build: linha_oh=8'h20 while valid.
- cdl=4'b1010, press -> erro high for exactly ERR_HOLD=8 cycles, mdl_valid never asserted, mdl keeps its previous value.
- Bouncy confirma (toggling every 2 cycles for 12 cycles, then stable high), DEB_CYCLES=4 -> exactly one press event and one capture.
- In VALID (cdl=4'b0011, no ack), second press with cdl=4'b0110 -> ignored; after ack, mdl is still 3'b011 and there is no second mdl_valid.
- Reset asserted during ERROR at count 5 and during VALID -> next cycle all outputs 0, state IDLE; a subsequent legal press works normally.
